// File: rtl/dmx_fixture_tx_pkg.sv
// Shared definitions for the DMX512 fixture transmitter.
// Contents: FSM state encodings, the DMX start code, default bit-time
// constants and the coordinate-to-byte mapping helper.
package dmx_fixture_tx_pkg;

    // FSM state encodings
    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StBreak = 3'd1;
    localparam logic [2:0] StMab   = 3'd2;
    localparam logic [2:0] StSlot  = 3'd3;
    localparam logic [2:0] StMtbp  = 3'd4;

    localparam logic [7:0] DmxStartCode = 8'h00;

    // Default bit-time constants (65 MHz clock, 250 kbaud)
    localparam int unsigned DefClksPerBit = 260;
    localparam int unsigned DefBreakBits  = 24;
    localparam int unsigned DefMabBits    = 3;
    localparam int unsigned DefMtbpBits   = 2;

    // start bit + 8 data bits + 2 stop bits
    localparam int unsigned SlotBits = 11;

    // Offset-subtract, divide by 4, clamp to a byte. Underflow clamps to 0.
    function automatic logic [7:0] map_coord(input logic [11:0] val, input logic [11:0] off);
        logic [11:0] diff;
        if (val < off) begin
            return 8'h00;
        end
        diff = (val - off) >> 2;
        if (diff > 12'd255) begin
            return 8'hFF;
        end
        return diff[7:0];
    endfunction

endpackage

// File: rtl/dmx_fixture_tx_slot_ser.sv
// Serialises one DMX slot: start bit 0, data[0..7] LSB first, two stop bits 1.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   tick_i         bit tick from the baud counter
//   load_i         start a new slot with byte_i (takes priority over shifting)
//   byte_i         slot data byte
//   bit_next_o     line value for the next cycle (fed to the registered pin)
//   slot_done_o    pulse on the tick that ends the second stop bit
module dmx_fixture_tx_slot_ser
    import dmx_fixture_tx_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    output logic       bit_next_o,
    output logic       slot_done_o
);

    localparam logic [3:0] LastBit = 4'(SlotBits - 1);

    logic [10:0] shreg_q, shreg_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        active_q, active_d;

    assign slot_done_o = active_q && tick_i && (cnt_q == LastBit);

    always_comb begin
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (load_i) begin
            shreg_d  = {2'b11, byte_i, 1'b0};
            cnt_d    = 4'd0;
            active_d = 1'b1;
        end else if (active_q && tick_i) begin
            // Shift in ones so the line idles at mark after the last stop bit
            shreg_d = {1'b1, shreg_q[10:1]};
            if (cnt_q == LastBit) begin
                cnt_d    = 4'd0;
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    assign bit_next_o = shreg_d[0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_q  <= '1;
            cnt_q    <= 4'd0;
            active_q <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/dmx_fixture_tx.sv
// DMX512 fixture transmitter. Captures tracker centre-of-mass updates, maps
// them to pan/tilt bytes and sends frames continuously while enabled:
// break, mark-after-break, start code, NUM_SLOTS data slots, inter-frame mark.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   x_com_i, y_com_i  tracked coordinates, valid with data_ready_i
//   data_ready_i      one-cycle strobe for a new coordinate pair
//   enable_i          1 = back-to-back frames; 0 = stop at the end of the frame
//   dimmer_i          intensity byte, sampled at break entry
//   dmx_out_o         registered serial line, mark = 1
//   busy_o            high outside IDLE
//   frame_done_o      pulse on the last cycle of the inter-frame mark
module dmx_fixture_tx
    import dmx_fixture_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefClksPerBit,
    parameter int unsigned BREAK_BITS   = DefBreakBits,
    parameter int unsigned MAB_BITS     = DefMabBits,
    parameter int unsigned MTBP_BITS    = DefMtbpBits,
    parameter int unsigned NUM_SLOTS    = 8,
    parameter int unsigned PAN_SLOT     = 1,
    parameter int unsigned TILT_SLOT    = 2,
    parameter int unsigned DIM_SLOT     = 3,
    parameter int unsigned X_OFF        = 33,
    parameter int unsigned Y_OFF        = 70
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [10:0] x_com_i,
    input  logic [9:0]  y_com_i,
    input  logic        data_ready_i,
    input  logic        enable_i,
    input  logic [7:0]  dimmer_i,
    output logic        dmx_out_o,
    output logic        busy_o,
    output logic        frame_done_o
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned SlotW = 10;

    localparam logic [BaudW-1:0] BaudLast  = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]       BreakLast = 8'(BREAK_BITS - 1);
    localparam logic [7:0]       MabLast   = 8'(MAB_BITS - 1);
    localparam logic [7:0]       MtbpLast  = 8'(MTBP_BITS - 1);
    localparam logic [SlotW-1:0] SlotLast  = SlotW'(NUM_SLOTS);
    localparam logic [SlotW-1:0] PanIdx    = SlotW'(PAN_SLOT);
    localparam logic [SlotW-1:0] TiltIdx   = SlotW'(TILT_SLOT);
    localparam logic [SlotW-1:0] DimIdx    = SlotW'(DIM_SLOT);

    logic [2:0]       state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [7:0]       bit_cnt_q, bit_cnt_d;
    logic [SlotW-1:0] slot_idx_q, slot_idx_d;
    logic [7:0]       pan_cap_q, pan_cap_d;
    logic [7:0]       tilt_cap_q, tilt_cap_d;
    logic [7:0]       pan_frm_q, tilt_frm_q, dim_frm_q;
    logic             dmx_out_q, dmx_out_d;

    logic       tick;
    logic       snapshot;
    logic       ser_load;
    logic [7:0] ser_byte;
    logic       ser_bit_next;
    logic       ser_done;
    logic       frame_done;

    assign tick = (state_q != StIdle) && (baud_q == BaudLast);

    // Baud counter is held at zero in IDLE so a frame always starts on a fresh bit
    always_comb begin
        if (state_q == StIdle || tick) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + 1'b1;
        end
    end

    // Capture path; a strobe during a frame only touches these registers
    always_comb begin
        pan_cap_d  = pan_cap_q;
        tilt_cap_d = tilt_cap_q;
        if (data_ready_i) begin
            pan_cap_d  = map_coord({1'b0, x_com_i}, 12'(X_OFF));
            tilt_cap_d = map_coord({2'b00, y_com_i}, 12'(Y_OFF));
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        slot_idx_d = slot_idx_q;
        snapshot   = 1'b0;
        ser_load   = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            StIdle: begin
                if (enable_i) begin
                    state_d   = StBreak;
                    bit_cnt_d = 8'd0;
                    snapshot  = 1'b1;
                end
            end
            StBreak: begin
                if (tick) begin
                    if (bit_cnt_q == BreakLast) begin
                        state_d   = StMab;
                        bit_cnt_d = 8'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 8'd1;
                    end
                end
            end
            StMab: begin
                if (tick) begin
                    if (bit_cnt_q == MabLast) begin
                        state_d    = StSlot;
                        bit_cnt_d  = 8'd0;
                        slot_idx_d = '0;
                        ser_load   = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 8'd1;
                    end
                end
            end
            StSlot: begin
                if (ser_done) begin
                    if (slot_idx_q == SlotLast) begin
                        state_d   = StMtbp;
                        bit_cnt_d = 8'd0;
                    end else begin
                        slot_idx_d = slot_idx_q + 1'b1;
                        ser_load   = 1'b1;
                    end
                end
            end
            StMtbp: begin
                if (tick) begin
                    if (bit_cnt_q == MtbpLast) begin
                        frame_done = 1'b1;
                        bit_cnt_d  = 8'd0;
                        if (enable_i) begin
                            state_d  = StBreak;
                            snapshot = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Slot data mux, indexed by the slot about to be loaded
    always_comb begin
        ser_byte = DmxStartCode;
        if (slot_idx_d != '0) begin
            if (slot_idx_d == PanIdx) begin
                ser_byte = pan_frm_q;
            end else if (slot_idx_d == TiltIdx) begin
                ser_byte = tilt_frm_q;
            end else if (slot_idx_d == DimIdx) begin
                ser_byte = dim_frm_q;
            end
        end
    end

    dmx_fixture_tx_slot_ser u_slot_ser (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .tick_i     (tick),
        .load_i     (ser_load),
        .byte_i     (ser_byte),
        .bit_next_o (ser_bit_next),
        .slot_done_o(ser_done)
    );

    // Line value follows the next state so the pin changes on the same edge as the FSM
    always_comb begin
        case (state_d)
            StBreak: dmx_out_d = 1'b0;
            StSlot:  dmx_out_d = ser_bit_next;
            default: dmx_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_cnt_q  <= 8'd0;
            slot_idx_q <= '0;
            pan_cap_q  <= 8'd0;
            tilt_cap_q <= 8'd0;
            pan_frm_q  <= 8'd0;
            tilt_frm_q <= 8'd0;
            dim_frm_q  <= 8'd0;
            dmx_out_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_cnt_q  <= bit_cnt_d;
            slot_idx_q <= slot_idx_d;
            pan_cap_q  <= pan_cap_d;
            tilt_cap_q <= tilt_cap_d;
            dmx_out_q  <= dmx_out_d;
            // Snapshot uses the pre-update capture values
            if (snapshot) begin
                pan_frm_q  <= pan_cap_q;
                tilt_frm_q <= tilt_cap_q;
                dim_frm_q  <= dimmer_i;
            end
        end
    end

    assign dmx_out_o    = dmx_out_q;
    assign busy_o       = (state_q != StIdle);
    assign frame_done_o = frame_done;

endmodule

// File: tb/tb_dmx_fixture_tx.sv
module tb_dmx_fixture_tx;

    localparam int unsigned CPB        = 8;
    localparam int unsigned BRK        = 24;
    localparam int unsigned MAB        = 3;
    localparam int unsigned MTBP       = 2;
    localparam int unsigned NSL        = 8;
    localparam int unsigned FRAME_CLKS = (BRK + MAB + 11 * (NSL + 1) + MTBP) * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] x_com;
    logic [9:0]  y_com;
    logic        data_ready;
    logic        enable;
    logic [7:0]  dimmer;
    logic        dmx_out;
    logic        busy;
    logic        frame_done;

    always #5 clk = ~clk;

    dmx_fixture_tx #(
        .CLKS_PER_BIT(CPB),
        .BREAK_BITS  (BRK),
        .MAB_BITS    (MAB),
        .MTBP_BITS   (MTBP),
        .NUM_SLOTS   (NSL)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .x_com_i     (x_com),
        .y_com_i     (y_com),
        .data_ready_i(data_ready),
        .enable_i    (enable),
        .dimmer_i    (dimmer),
        .dmx_out_o   (dmx_out),
        .busy_o      (busy),
        .frame_done_o(frame_done)
    );

    typedef struct {
        logic [10:0] x;
        logic [9:0]  y;
        logic [7:0]  dim;
        logic [7:0]  pan;
        logic [7:0]  tilt;
    } vec_t;

    typedef struct {
        int               tag;
        logic [8:0][7:0]  b;
    } frame_t;

    vec_t   vecs[7];
    frame_t exp_q[$];

    int n_checks   = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int fd_pulses  = 0;
    int frames     = 0;
    int dec_idx    = 0;
    bit dec_en     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (frame_done === 1'b1) fd_pulses <= fd_pulses + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic push_exp(input int tag, input logic [7:0] pan, input logic [7:0] tilt,
                            input logic [7:0] dim);
        frame_t e;
        e.tag  = tag;
        e.b    = '0;
        e.b[1] = pan;
        e.b[2] = tilt;
        e.b[3] = dim;
        exp_q.push_back(e);
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < int'(2 * FRAME_CLKS));
        if (frame_done !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_frame_done: got no pulse, expected one within %0d cycles", n);
        end
        frames++;
    endtask

    // Line decoder: measures break/MAB and samples every slot bit mid-bit.
    initial begin : decoder
        int              low_n;
        int              high_n;
        logic [7:0]      by;
        logic [8:0][7:0] fr;
        logic            s;
        frame_t          e;
        wait (dec_en);
        forever begin
            @(negedge clk);
            if (dmx_out === 1'b0) begin
                low_n = 0;
                while (dmx_out === 1'b0) begin
                    low_n++;
                    @(negedge clk);
                end
                check("break_len", low_n, BRK * CPB);
                high_n = 0;
                while (dmx_out === 1'b1) begin
                    high_n++;
                    @(negedge clk);
                end
                check("mab_len", high_n, MAB * CPB);
                repeat (CPB / 2) @(negedge clk);
                by = '0;
                for (int sl = 0; sl <= int'(NSL); sl++) begin
                    for (int b = 0; b < 11; b++) begin
                        if (!(sl == 0 && b == 0)) repeat (CPB) @(negedge clk);
                        s = dmx_out;
                        if (b == 0) check($sformatf("start_bit_s%0d", sl), s, 0);
                        else if (b <= 8) by[b-1] = s;
                        else check($sformatf("stop_bit_s%0d", sl), s, 1);
                    end
                    fr[sl] = by;
                end
                check("start_code", fr[0], 8'h00);
                if (exp_q.size() > 0 && exp_q[0].tag == dec_idx) begin
                    e = exp_q.pop_front();
                    for (int i = 0; i <= int'(NSL); i++)
                        check($sformatf("frame%0d_slot%0d", dec_idx, i), fr[i], e.b[i]);
                end
                dec_idx++;
            end
        end
    end

    initial begin : main
        int bad;
        int last_cyc;
        int p0;

        // {x, y, dimmer, expected pan, expected tilt}
        vecs[0] = '{11'd433,  10'd470,  8'hC8, 8'h64, 8'h64};
        vecs[1] = '{11'd2000, 10'd470,  8'h11, 8'hFF, 8'h64};
        vecs[2] = '{11'd10,   10'd5,    8'h22, 8'h00, 8'h00};
        vecs[3] = '{11'd1056, 10'd1023, 8'h33, 8'hFF, 8'hEE};
        vecs[4] = '{11'd1052, 10'd74,   8'h44, 8'hFE, 8'h01};
        vecs[5] = '{11'd1057, 10'd73,   8'h55, 8'hFF, 8'h00};
        vecs[6] = '{11'd37,   10'd69,   8'h66, 8'h01, 8'h00};

        rst        = 1'b1;
        enable     = 1'b0;
        data_ready = 1'b0;
        x_com      = '0;
        y_com      = '0;
        dimmer     = '0;
        repeat (3) @(negedge clk);
        check("reset_dmx_out", dmx_out, 1);
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        rst = 1'b0;

        // Reset in the middle of the start-code slot (line low there)
        enable = 1'b1;
        repeat ((BRK + MAB + 5) * CPB) @(negedge clk);
        check("t1_busy_before_reset", busy, 1);
        check("t1_line_low_before_reset", dmx_out, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t1_async_dmx_out", dmx_out, 1);
        check("t1_async_busy", busy, 0);
        check("t1_async_frame_done", frame_done, 0);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (2000) begin
            @(negedge clk);
            if (dmx_out !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("t1_idle_line_high", bad, 0);

        // Continuous frames with table-driven coordinate updates
        dec_en = 1'b1;
        @(negedge clk);
        enable   = 1'b1;
        last_cyc = 0;
        for (int i = 0; i < 7; i++) begin
            wait_fd();
            if (i > 0) check("frame_period", cyc - last_cyc, FRAME_CLKS);
            last_cyc = cyc;
            repeat (3) @(negedge clk);
            x_com      = vecs[i].x;
            y_com      = vecs[i].y;
            dimmer     = vecs[i].dim;
            data_ready = 1'b1;
            push_exp(frames + 1, vecs[i].pan, vecs[i].tilt, vecs[i].dim);
            @(negedge clk);
            data_ready = 1'b0;
        end

        // Update during slot 4: running frame keeps old values, next frame gets 0x32
        wait_fd();
        check("frame_period", cyc - last_cyc, FRAME_CLKS);
        repeat ((BRK + MAB + 11 * 4 + 5) * CPB) @(negedge clk);
        check("t5_busy_mid_frame", busy, 1);
        x_com      = 11'd233;
        y_com      = 10'd470;
        data_ready = 1'b1;
        push_exp(frames + 1, 8'h32, 8'h64, 8'h66);
        @(negedge clk);
        data_ready = 1'b0;

        // Drop enable during slot 2 of the following frame
        wait_fd();
        repeat ((BRK + MAB + 11 * 2 + 5) * CPB) @(negedge clk);
        enable = 1'b0;
        check("t6_busy_after_drop", busy, 1);
        wait_fd();
        @(posedge clk);
        p0 = fd_pulses;
        check("t6_total_frame_done", p0, 10);
        @(negedge clk);
        check("t6_idle_busy", busy, 0);
        bad = 0;
        repeat (3 * FRAME_CLKS) begin
            @(negedge clk);
            if (dmx_out !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("t6_line_held_idle", bad, 0);
        check("t6_no_extra_frame_done", fd_pulses - p0, 0);
        check("frames_decoded", dec_idx, 10);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
